romix_sequencer: RTL and testbench

ROMIX_SEQUENCER -- requirements
Module: romix_sequencer

---
 rtl/romix_sequencer.sv | 173 +++++++++++++++++
 tb/tb_romix_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/romix_sequencer.sv
// ROMix sequencer: drives the scratchpad-fill (write) phase followed by the
// data-dependent read-mix phase. Each phase issues iter_max+1 iterations and
// launches the external hash core once per iteration, waiting for its
// completion strobe. All outputs are decoded from the registered state and
// counters; the only combinational path is rd_index -> mem_addr in R_ADDR.
module romix_sequencer #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADDR_BITS-1:0] iter_max,
    input  logic [ADDR_BITS-1:0] rd_index,
    input  logic                 core_done,
    output logic                 core_start,
    output logic                 mem_we,
    output logic                 mem_re,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 phase,
    output logic [ADDR_BITS-1:0] iter_count,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_W_MEM  = 3'd1,
        ST_W_KICK = 3'd2,
        ST_W_WAIT = 3'd3,
        ST_R_ADDR = 3'd4,
        ST_R_KICK = 3'd5,
        ST_R_WAIT = 3'd6,
        ST_FIN    = 3'd7
    } state_t;

    localparam logic [ADDR_BITS-1:0] CNT_ONE = ADDR_BITS'(1);

    state_t                 state_r;
    state_t                 state_s;
    logic [ADDR_BITS-1:0]   iter_r;
    logic [ADDR_BITS-1:0]   iter_s;
    logic [ADDR_BITS-1:0]   max_r;
    logic [ADDR_BITS-1:0]   max_s;
    logic                   phase_r;
    logic                   phase_s;
    logic                   last_iter_s;

    // The equality test happens before any increment, so an all-ones limit
    // runs the full 2^ADDR_BITS iterations without the counter wrapping.
    assign last_iter_s = (iter_r == max_r);

    // State, iteration counter, phase flag and captured limit registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= ST_IDLE;
            iter_r  <= '0;
            max_r   <= '0;
            phase_r <= 1'b0;
        end else begin
            state_r <= state_s;
            iter_r  <= iter_s;
            max_r   <= max_s;
            phase_r <= phase_s;
        end
    end

    // Next-state and counter update; abort overrides every transition.
    always_comb begin
        state_s = state_r;
        iter_s  = iter_r;
        max_s   = max_r;
        phase_s = phase_r;
        if (abort) begin
            state_s = ST_IDLE;
            iter_s  = '0;
            phase_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        max_s   = iter_max;
                        iter_s  = '0;
                        phase_s = 1'b0;
                        state_s = ST_W_MEM;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_W_MEM: begin
                    state_s = ST_W_KICK;
                end
                ST_W_KICK: begin
                    state_s = ST_W_WAIT;
                end
                ST_W_WAIT: begin
                    if (core_done && last_iter_s) begin
                        iter_s  = '0;
                        phase_s = 1'b1;
                        state_s = ST_R_ADDR;
                    end else if (core_done) begin
                        iter_s  = iter_r + CNT_ONE;
                        state_s = ST_W_MEM;
                    end else begin
                        state_s = ST_W_WAIT;
                    end
                end
                ST_R_ADDR: begin
                    state_s = ST_R_KICK;
                end
                ST_R_KICK: begin
                    state_s = ST_R_WAIT;
                end
                ST_R_WAIT: begin
                    if (core_done && last_iter_s) begin
                        state_s = ST_FIN;
                    end else if (core_done) begin
                        iter_s  = iter_r + CNT_ONE;
                        state_s = ST_R_ADDR;
                    end else begin
                        state_s = ST_R_WAIT;
                    end
                end
                ST_FIN: begin
                    iter_s  = '0;
                    phase_s = 1'b0;
                    state_s = ST_IDLE;
                end
                default: begin
                    iter_s  = '0;
                    phase_s = 1'b0;
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Moore output decode; everything not asserted by a state stays at zero.
    always_comb begin
        core_start = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = '0;
        done       = 1'b0;
        case (state_r)
            ST_W_MEM: begin
                mem_we   = 1'b1;
                mem_addr = iter_r;
            end
            ST_W_KICK: begin
                core_start = 1'b1;
            end
            ST_R_ADDR: begin
                mem_re   = 1'b1;
                mem_addr = rd_index;
            end
            ST_R_KICK: begin
                core_start = 1'b1;
            end
            ST_FIN: begin
                done = 1'b1;
            end
            default: begin
                core_start = 1'b0;
            end
        endcase
    end

    assign phase      = phase_r;
    assign iter_count = iter_r;
    assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_romix_sequencer.sv
// Scoreboard bench for romix_sequencer (ADDR_BITS=4). The stimulus side pushes
// the event list a run must produce (writes, kicks, reads, done); a monitor
// pops and compares on every strobe, including the cycle spacing implied by
// the hash-core responder's chosen latency.
module tb_romix_sequencer;

    localparam int AB = 4;
    localparam int K_W = 0, K_R = 1, K_K = 2, K_D = 3, K_NONE = 4;

    typedef struct {
        int kind;
        int iter;
        int ph;
    } ev_t;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AB-1:0] iter_max = '0;
    logic [AB-1:0] rd_index = '0;
    logic          core_done = 1'b0;
    logic          core_start;
    logic          mem_we;
    logic          mem_re;
    logic [AB-1:0] mem_addr;
    logic          phase;
    logic [AB-1:0] iter_count;
    logic          busy;
    logic          done;

    int  n_checks = 0;
    int  n_fail = 0;
    int  cyc = 0;
    ev_t exp_q[$];
    int  last_kind = K_NONE;
    int  last_cyc = 0;
    int  exp_gap = 2;
    int  kick_cnt = 0;
    bit  done_seen = 1'b0;
    bit  noise = 1'b0;
    bit  pend = 1'b0;
    int  done_cyc = 0;

    romix_sequencer #(.ADDR_BITS(AB)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
        .iter_max(iter_max), .rd_index(rd_index), .core_done(core_done),
        .core_start(core_start), .mem_we(mem_we), .mem_re(mem_re),
        .mem_addr(mem_addr), .phase(phase), .iter_count(iter_count),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1 rd_index = AB'($urandom);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Hash-core stand-in: a completion pulse 1..4 cycles after each launch,
    // or core_done held high permanently in noise mode.
    always @(negedge clk) begin
        int d;
        if (!n_rst) begin
            pend = 1'b0;
            core_done = noise;
        end else begin
            if (noise) core_done = 1'b1;
            else core_done = pend && (cyc == done_cyc);
            if (pend && cyc == done_cyc) pend = 1'b0;
            if (core_start) begin
                d = $urandom_range(0, 3);
                if (noise) begin
                    exp_gap = 2;
                end else begin
                    done_cyc = cyc + 1 + d;
                    pend = 1'b1;
                    exp_gap = d + 2;
                end
            end
        end
    end

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        int  nact;
        int  kind;
        int  exp_addr;
        ev_t e;
        if (!n_rst) begin
            last_kind = K_NONE;
        end else begin
            nact = int'(mem_we) + int'(mem_re) + int'(core_start) + int'(done);
            if (nact == 0) begin
                chk("quiet_addr_zero", int'(mem_addr), 0);
            end else begin
                chk("single_strobe", nact, 1);
                kind = mem_we ? K_W : (mem_re ? K_R : (core_start ? K_K : K_D));
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got kind %0d expected no event (cycle %0d)", kind, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", kind, e.kind);
                    if (e.kind != K_D) begin
                        chk("iter_count", int'(iter_count), e.iter);
                        chk("phase", int'(phase), e.ph);
                    end
                    exp_addr = (e.kind == K_W) ? e.iter : ((e.kind == K_R) ? int'(rd_index) : 0);
                    chk("mem_addr", int'(mem_addr), exp_addr);
                    chk("busy_in_run", int'(busy), 1);
                    if (last_kind == K_K) chk("kick_to_next_gap", cyc - last_cyc, exp_gap);
                    else if (last_kind == K_W || last_kind == K_R) chk("mem_to_kick_gap", cyc - last_cyc, 1);
                end
                if (kind == K_K) kick_cnt++;
                if (kind == K_D) done_seen = 1'b1;
                last_kind = kind;
                last_cyc = cyc;
            end
            if (!busy) last_kind = K_NONE;
        end
    end

    // Reference model: a run is m+1 write iterations then m+1 read iterations.
    task automatic push_run(input int m);
        for (int i = 0; i <= m; i++) begin
            exp_q.push_back('{K_W, i, 0});
            exp_q.push_back('{K_K, i, 0});
        end
        for (int i = 0; i <= m; i++) begin
            exp_q.push_back('{K_R, i, 1});
            exp_q.push_back('{K_K, i, 1});
        end
        exp_q.push_back('{K_D, 0, 0});
    endtask

    task automatic launch(input int m);
        @(posedge clk); #1;
        start = 1'b1;
        iter_max = AB'(m);
        @(posedge clk); #1;
        start = 1'b0;
        iter_max = AB'($urandom);
    endtask

    task automatic check_idle(input string nm);
        @(negedge clk);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_iter"}, int'(iter_count), 0);
        chk({nm, "_phase"}, int'(phase), 0);
        chk({nm, "_queue_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_core_start"}, int'(core_start), 0);
        chk({nm, "_mem_we"}, int'(mem_we), 0);
        chk({nm, "_mem_re"}, int'(mem_re), 0);
        chk({nm, "_done"}, int'(done), 0);
        chk({nm, "_mem_addr"}, int'(mem_addr), 0);
        chk({nm, "_phase"}, int'(phase), 0);
        chk({nm, "_iter"}, int'(iter_count), 0);
    endtask

    task automatic do_run(input int m, input bit disturb);
        done_seen = 1'b0;
        push_run(m);
        launch(m);
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (done_seen) break;
            if (disturb) begin
                start = ((i % 5) == 0);
                iter_max = AB'(7);
            end
        end
        start = 1'b0;
        chk("run_completed", int'(done_seen), 1);
        check_idle("after_run");
    endtask

    task automatic wait_kicks(input int n);
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (kick_cnt >= n) break;
        end
        chk("kick_wait", int'(kick_cnt >= n), 1);
    endtask

    initial begin
        #3;
        check_all_zero("reset_state");
        repeat (3) @(negedge clk);
        #1 n_rst = 1'b1;
        repeat (2) @(posedge clk);

        do_run(3, 1'b0);
        do_run(0, 1'b0);

        noise = 1'b1;
        do_run(2, 1'b0);
        noise = 1'b0;
        repeat (2) @(posedge clk);

        // Abort while waiting on read iteration 2 (write kicks 0..4, read kicks 0..2).
        kick_cnt = 0;
        done_seen = 1'b0;
        push_run(4);
        launch(4);
        wait_kicks(8);
        abort = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_iter", int'(iter_count), 0);
        chk("abort_phase", int'(phase), 0);
        repeat (10) @(posedge clk);
        chk("abort_no_done", int'(done_seen), 0);
        do_run(1, 1'b0);

        // Asynchronous reset in the write-phase wait of iteration 3.
        kick_cnt = 0;
        push_run(5);
        launch(5);
        wait_kicks(4);
        #2 n_rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1 n_rst = 1'b1;
        repeat (3) @(posedge clk);
        do_run(2, 1'b1);

        for (int r = 0; r < 4; r++) do_run($urandom_range(0, 14), 1'b0);
        do_run(15, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
